msk_mixcolumns_pipe: RTL and testbench
======================================

// Module: msk_mixcolumns_pipe
// PURPOSE
// - Masked (d-share) AES MixColumns on one 32-bit column per transfer.
// - Share-wise linear datapath: each share is processed independently, with no share mixing
//   and no randomness.
// - Elastic valid/ready pipeline of PIPE register stages.
// - Tags each column with its index in the state (0..3).
// - Sits between the masked ShiftRows wiring and AddRoundKey in the 32-bit datapath.
// PARAMETERS
// - d     2  number of shares (>=2)
// - PIPE  1  number of register stages, 1..4 (0 is illegal)
// PORTS
// - clk        in   1      clock, rising edge
// - rst        in   1      synchronous, active-high reset
// - in_valid   in   1      input column valid
// - in_ready   out  1      block can accept a column this cycle
// - in_inverse in   1      1 = InvMixColumns; only effective with MSK_MC_INV_EN
// - sh_col_in  in   32*d   masked column; byte r (row r) at [8*d*r +: 8*d]; bit i of share j at offset i*d+j
// - out_valid  out  1      output column valid
// - out_ready  in   1      downstream accepts
// - sh_col_out out  32*d   masked result, same layout as sh_col_in
// - out_idx    out  2      column index of the output (0..3)
// - out_last   out  1      out_idx==3
// BEHAVIOUR
// - Per share s and row r, with a = input bytes of share s, indices mod 4:
//   `o[r] = xt(a[r]) ^ xt(a[r+1]) ^ a[r+1] ^ a[r+2] ^ a[r+3]`
// - xt(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00).
// - Output sharing recombines to MixColumns of the recombined input. The masks are not
//   refreshed; each output share depends only on the same input share.
// - Transfer rule: an input is accepted when in_valid & in_ready; an output is consumed when
//   out_valid & out_ready.
// - Each stage k holds {valid, data, idx, inv}.
//   - Stage k loads when it is empty or its content leaves in the same cycle.
//   - `in_ready = !v[0] | ready[1]`; the last stage uses `ready = out_ready`.
//   - No combinational path from in_valid to out_valid.
// - Arithmetic sits in front of stage 0, so latency is exactly PIPE cycles with out_ready held
//   at 1.
// - Throughput is 1 column/cycle; full rate under continuous flow.
// - Backpressure: with out_ready=0, the pipe fills after PIPE accepts and in_ready drops to 0.
//   - Held data is stable while out_valid=1 and out_ready=0.
//   - Simultaneous pop and push on a full pipe is allowed and loses no data.
// - Column counter: 2-bit, increments on each accepted input and wraps 3->0. The value is
//   captured with the column and travels as out_idx.
// - Reset (any cycle, including mid-stream):
//   - all stage valids = 0, all data/idx/inv registers = 0, column counter = 0;
//   - in-flight columns are dropped;
//   - on the reset cycle: out_valid=0, sh_col_out=0, out_idx=0, out_last=0; in_ready=1 from
//     the first cycle after rst deasserts.
// - Input data is don't-care when in_valid=0, but must not propagate (the stage stays invalid).
// CONFIGURATION
// - MSK_MC_INV_EN defined:
//   - in_inverse is sampled with each accepted column and carried in the pipe.
//   - inv=1 computes InvMixColumns per share, using coefficients {0e,0b,0d,09} built from
//     chained xt.
//   - Latency and handshake are unchanged.
// - MSK_MC_INV_EN undefined:
//   - in_inverse is ignored and no inverse logic is synthesised;
//   - the block always computes forward MixColumns.
// TESTING
// - fwd, d=2, PIPE=1:
//   - Stimulus: column db,13,53,45 (rows 0..3), share0 random, share1 = col^share0.
//   - Expected: recombined out = 8e,4d,a1,bc after 1 cycle, out_idx=0.
// - Invariants, with d=3 and random masks:
//   - column c6c6c6c6 -> c6c6c6c6 and 01010101 -> 01010101;
//   - each output share equals the per-share golden model.
// - Stream and index wrap, PIPE=3:
//   - Stimulus: 6 back-to-back columns with out_ready=1.
//   - Expected: outputs in order after 3 cycles, out_idx 0,1,2,3,0,1, out_last on the 4th only.
// - Backpressure, PIPE=2:
//   - Stimulus: out_ready=0 for 5 cycles while in_valid=1.
//   - Expected: exactly 2 accepts and in_ready=0; out data stable; after release, no loss or
//     duplication.
// - Reset mid-stream:
//   - Stimulus: assert rst with 2 columns in flight.
//   - Expected: next cycle out_valid=0; next accepted column gets out_idx=0.
// - With MSK_MC_INV_EN:
//   - in_inverse=1 on 8e,4d,a1,bc -> db,13,53,45;
//   - interleaved fwd/inv columns give correct per-column results.

Source files
------------

// File: rtl/msk_mixcolumns_pipe.sv
// Masked (d-share) AES MixColumns on one 32-bit column per transfer, elastic PIPE-stage pipe.
// Define MSK_MC_INV_EN to add per-column InvMixColumns selected by in_inverse.
module msk_mixcolumns_pipe #(
  parameter int d    = 2,
  parameter int PIPE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_inverse,
  input  logic [32*d-1:0] sh_col_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [32*d-1:0] sh_col_out,
  output logic [1:0]      out_idx,
  output logic            out_last
);
  localparam int W = 32*d;

  if (d < 2) begin : g_bad_d
    $error("msk_mixcolumns_pipe: d must be >= 2");
  end
  if (PIPE < 1 || PIPE > 4) begin : g_bad_pipe
    $error("msk_mixcolumns_pipe: PIPE must be in 1..4");
  end

  typedef logic [3:0][7:0] col_t;

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic col_t mix_fwd(input col_t a);
    col_t o;
    for (int r = 0; r < 4; r++) begin
      o[r] = xt(a[r]) ^ xt(a[(r+1)%4]) ^ a[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
    end
    return o;
  endfunction

`ifdef MSK_MC_INV_EN
  // Coefficients 09/0b/0d/0e are built from the chained doublings x2, x4, x8.
  function automatic col_t mix_inv(input col_t a);
    col_t o, x2, x4, x8, m9, mb, md, me;
    for (int r = 0; r < 4; r++) begin
      x2[r] = xt(a[r]);
      x4[r] = xt(x2[r]);
      x8[r] = xt(x4[r]);
      m9[r] = x8[r] ^ a[r];
      mb[r] = x8[r] ^ x2[r] ^ a[r];
      md[r] = x8[r] ^ x4[r] ^ a[r];
      me[r] = x8[r] ^ x4[r] ^ x2[r];
    end
    for (int r = 0; r < 4; r++) begin
      o[r] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
    end
    return o;
  endfunction
`endif

  // Share split: bit i of share s in row r lives at 8*d*r + i*d + s.
  col_t [d-1:0] sh_a;
  col_t [d-1:0] sh_m;
  logic [W-1:0] mc_data;

  always_comb begin
    sh_a = '0;
    for (int s = 0; s < d; s++) begin
      for (int r = 0; r < 4; r++) begin
        for (int i = 0; i < 8; i++) begin
          sh_a[s][r][i] = sh_col_in[8*d*r + i*d + s];
        end
      end
    end
  end

  always_comb begin
    sh_m = '0;
    for (int s = 0; s < d; s++) begin
`ifdef MSK_MC_INV_EN
      sh_m[s] = in_inverse ? mix_inv(sh_a[s]) : mix_fwd(sh_a[s]);
`else
      sh_m[s] = mix_fwd(sh_a[s]);
`endif
    end
  end

  always_comb begin
    mc_data = '0;
    for (int s = 0; s < d; s++) begin
      for (int r = 0; r < 4; r++) begin
        for (int i = 0; i < 8; i++) begin
          mc_data[8*d*r + i*d + s] = sh_m[s][r][i];
        end
      end
    end
  end

  // Handshake: a column moves on a cycle where valid & ready are both high; valid never
  // waits on ready, data is held while valid & !ready, and ready only looks downstream.
  logic [PIPE-1:0] stg_v;
  logic [W-1:0]    stg_data [PIPE];
  logic [1:0]      stg_idx  [PIPE];
  logic [PIPE-1:0] stg_rdy;
  logic [1:0]      col_cnt;
  logic            accept;

  // Stage k may load when any stage from k to the output is empty or the output drains.
  always_comb begin
    logic acc;
    acc = out_ready;
    stg_rdy = '0;
    for (int k = PIPE-1; k >= 0; k--) begin
      acc        = acc | !stg_v[k];
      stg_rdy[k] = acc;
    end
  end

  assign in_ready = !rst & stg_rdy[0];
  assign accept   = in_valid & in_ready;

`ifdef MSK_MC_INV_EN
  logic [PIPE-1:0] stg_inv;
  logic            unused_inv_tail;
  assign unused_inv_tail = stg_inv[PIPE-1];
`else
  logic unused_inverse;
  assign unused_inverse = in_inverse;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      stg_v   <= '0;
      col_cnt <= '0;
      for (int k = 0; k < PIPE; k++) begin
        stg_data[k] <= '0;
        stg_idx[k]  <= '0;
      end
`ifdef MSK_MC_INV_EN
      stg_inv <= '0;
`endif
    end else begin
      if (accept) begin
        col_cnt <= col_cnt + 2'd1;
      end
      if (stg_rdy[0]) begin
        stg_v[0] <= in_valid;
        if (in_valid) begin
          stg_data[0] <= mc_data;
          stg_idx[0]  <= col_cnt;
`ifdef MSK_MC_INV_EN
          stg_inv[0]  <= in_inverse;
`endif
        end
      end
      for (int k = 1; k < PIPE; k++) begin
        if (stg_rdy[k]) begin
          stg_v[k] <= stg_v[k-1];
          if (stg_v[k-1]) begin
            stg_data[k] <= stg_data[k-1];
            stg_idx[k]  <= stg_idx[k-1];
`ifdef MSK_MC_INV_EN
            stg_inv[k]  <= stg_inv[k-1];
`endif
          end
        end
      end
    end
  end

  // Outputs are forced quiet during the reset cycle itself, before the registers clear.
  assign out_valid  = stg_v[PIPE-1] & !rst;
  assign sh_col_out = rst ? '0 : stg_data[PIPE-1];
  assign out_idx    = rst ? 2'd0 : stg_idx[PIPE-1];
  assign out_last   = (out_idx == 2'd3);

endmodule

// File: tb/tb_msk_mixcolumns_pipe.sv
// Bench for msk_mixcolumns_pipe: three configurations (d=2/PIPE=1, d=3/PIPE=3, d=2/PIPE=2)
// driven from one sequence, with a per-unit expected queue checked at the outputs.
module tb_msk_mixcolumns_pipe;
  localparam int EW = 147;  // {strict, accept_cycle[15:0], idx[1:0], plain[31:0], masked[95:0]}

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]      rst_u, in_valid, in_ready, in_inv, out_valid, out_ready, out_last;
  logic [2:0][1:0] out_idx;
  logic [63:0]     si_a, so_a, si_c, so_c;
  logic [95:0]     si_b, so_b;

  msk_mixcolumns_pipe #(.d(2), .PIPE(1)) u_a (
    .clk(clk), .rst(rst_u[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_inverse(in_inv[0]), .sh_col_in(si_a), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .sh_col_out(so_a), .out_idx(out_idx[0]), .out_last(out_last[0]));

  msk_mixcolumns_pipe #(.d(3), .PIPE(3)) u_b (
    .clk(clk), .rst(rst_u[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_inverse(in_inv[1]), .sh_col_in(si_b), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .sh_col_out(so_b), .out_idx(out_idx[1]), .out_last(out_last[1]));

  msk_mixcolumns_pipe #(.d(2), .PIPE(2)) u_c (
    .clk(clk), .rst(rst_u[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_inverse(in_inv[2]), .sh_col_in(si_c), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .sh_col_out(so_c), .out_idx(out_idx[2]), .out_last(out_last[2]));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [15:0] cyc = '0;
  always @(posedge clk) cyc <= cyc + 16'd1;

  typedef logic [2:0][31:0] shv_t;

  function automatic int nd_of(input int u);
    return (u == 1) ? 3 : 2;
  endfunction

  function automatic int pipe_of(input int u);
    return (u == 0) ? 1 : ((u == 1) ? 3 : 2);
  endfunction

  // Plain GF(2^8) multiply, independent of any doubling chain.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  // Column written with row 0 in the most significant byte.
  function automatic logic [31:0] mix_ref(input logic [31:0] col, input logic inv);
    logic [7:0] c [4];
    logic [7:0] a [4];
    logic [7:0] s;
    logic [31:0] o;
    if (inv) begin
      c[0] = 8'h0e; c[1] = 8'h0b; c[2] = 8'h0d; c[3] = 8'h09;
    end else begin
      c[0] = 8'h02; c[1] = 8'h03; c[2] = 8'h01; c[3] = 8'h01;
    end
    for (int r = 0; r < 4; r++) a[r] = col[31-8*r -: 8];
    o = '0;
    for (int r = 0; r < 4; r++) begin
      s = 8'h00;
      for (int j = 0; j < 4; j++) s = s ^ gmul(a[(r+j)%4], c[j]);
      o[31-8*r -: 8] = s;
    end
    return o;
  endfunction

  function automatic logic [95:0] share_pack(input shv_t sh, input int nd);
    logic [95:0] v;
    v = '0;
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < 8; i++)
        for (int s = 0; s < nd; s++)
          v[8*nd*r + i*nd + s] = sh[s][24-8*r+i];
    return v;
  endfunction

  function automatic logic [31:0] recomb(input logic [95:0] v, input int nd);
    logic [31:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < 8; i++)
        for (int s = 0; s < nd; s++)
          o[24-8*r+i] = o[24-8*r+i] ^ v[8*nd*r + i*nd + s];
    return o;
  endfunction

  function automatic logic eff_inv(input logic inv);
`ifdef MSK_MC_INV_EN
    return inv;
`else
    return 1'b0 & inv;
`endif
  endfunction

  function automatic logic [95:0] get_out(input int u);
    case (u)
      0:       return {32'h0, so_a};
      1:       return so_b;
      default: return {32'h0, so_c};
    endcase
  endfunction

  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  logic [EW-1:0] exp_q2[$];

  function automatic int qsize(input int u);
    case (u)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  task automatic push(input int u, input logic [EW-1:0] e);
    case (u)
      0:       exp_q0.push_back(e);
      1:       exp_q1.push_back(e);
      default: exp_q2.push_back(e);
    endcase
  endtask

  task automatic pop(input int u, output logic [EW-1:0] e);
    case (u)
      0:       e = exp_q0.pop_front();
      1:       e = exp_q1.pop_front();
      default: e = exp_q2.pop_front();
    endcase
  endtask

  logic [2:0]      strict;
  logic [2:0][1:0] cnt;
  logic [31:0]     pend_plain [3];
  logic [95:0]     pend_mask  [3];

  // Present a freshly masked column on unit u and remember its expected result.
  task automatic prep(input int u, input logic [31:0] col, input logic [31:0] exp_plain,
                      input logic inv);
    shv_t sh, shm;
    int nd;
    nd = nd_of(u);
    sh = '0; shm = '0;
    sh[0] = col;
    for (int s = 1; s < nd; s++) begin
      sh[s] = $urandom;
      sh[0] = sh[0] ^ sh[s];
    end
    for (int s = 0; s < nd; s++) shm[s] = mix_ref(sh[s], eff_inv(inv));
    pend_plain[u] = exp_plain;
    pend_mask[u]  = share_pack(shm, nd);
    case (u)
      0:       si_a = share_pack(sh, nd)[63:0];
      1:       si_b = share_pack(sh, nd);
      default: si_c = share_pack(sh, nd)[63:0];
    endcase
    in_inv[u]   = inv;
    in_valid[u] = 1'b1;
  endtask

  // One clock: decide on the falling edge whether the rising edge transfers the column.
  task automatic step(input int u, output logic acc);
    logic r;
    logic [15:0] c;
    @(negedge clk);
    r = in_valid[u] & in_ready[u];
    c = cyc;
    @(posedge clk);
    acc = r;
    if (r) begin
      push(u, {strict[u], c, cnt[u], pend_plain[u], pend_mask[u]});
      cnt[u] = cnt[u] + 2'd1;
    end
  endtask

  task automatic drive(input int u, input logic [31:0] col, input logic [31:0] exp_plain,
                       input logic inv, output int steps);
    logic acc;
    #1;
    prep(u, col, exp_plain, inv);
    acc = 1'b0;
    steps = 0;
    while (!acc && steps < 64) begin
      step(u, acc);
      steps++;
    end
    if (!acc) check("accept_timeout", 128'd0, 128'd1);
  endtask

  task automatic idle(input int u);
    #1;
    in_valid[u] = 1'b0;
  endtask

  logic [2:0]  hold_v = '0;
  logic [95:0] hold_d [3];

  always @(negedge clk) begin
    logic [EW-1:0] e;
    for (int u = 0; u < 3; u++) begin
      if (out_valid[u] && out_ready[u]) begin
        if (qsize(u) == 0) begin
          check($sformatf("u%0d_unexpected_out", u), 128'd1, 128'd0);
        end else begin
          pop(u, e);
          check($sformatf("u%0d_shares", u), get_out(u), e[95:0]);
          check($sformatf("u%0d_recombined", u), recomb(get_out(u), nd_of(u)), e[127:96]);
          check($sformatf("u%0d_idx", u), out_idx[u], e[129:128]);
          check($sformatf("u%0d_last", u), out_last[u], e[129:128] == 2'd3);
          if (e[146]) check($sformatf("u%0d_latency", u), cyc - e[145:130], pipe_of(u));
        end
      end
      if (hold_v[u] && !rst_u[u]) begin
        check($sformatf("u%0d_hold_valid", u), out_valid[u], 1'b1);
        check($sformatf("u%0d_hold_data", u), get_out(u), hold_d[u]);
      end
      hold_v[u] = out_valid[u] & !out_ready[u] & !rst_u[u];
      hold_d[u] = get_out(u);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] c;
    logic        iv, acc;
    int          steps, total, k;
    rst_u = '1; in_valid = '0; in_inv = '0; out_ready = '1;
    si_a = '0; si_b = '0; si_c = '0; strict = '1; cnt = '0;
    for (int u = 0; u < 3; u++) begin
      pend_plain[u] = '0; pend_mask[u] = '0; hold_d[u] = '0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      check("rst_out_valid", out_valid[u], 1'b0);
      check("rst_out_data", get_out(u), 96'h0);
      check("rst_out_idx", out_idx[u], 2'd0);
      check("rst_out_last", out_last[u], 1'b0);
    end
    @(posedge clk); #1 rst_u = '0;
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      check("post_rst_in_ready", in_ready[u], 1'b1);
      check("post_rst_out_valid", out_valid[u], 1'b0);
    end
    @(posedge clk);

    // Known forward vector, d=2, PIPE=1: visible one cycle after acceptance with idx 0
    drive(0, 32'hdb135345, 32'h8e4da1bc, 1'b0, steps);
    idle(0);
    @(negedge clk);
    check("a_vec_valid", out_valid[0], 1'b1);
    check("a_vec_plain", recomb(get_out(0), 2), 32'h8e4da1bc);
    check("a_vec_idx", out_idx[0], 2'd0);
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      c = $urandom;
      drive(0, c, mix_ref(c, 1'b0), 1'b0, steps);
    end
`ifdef MSK_MC_INV_EN
    drive(0, 32'h8e4da1bc, 32'hdb135345, 1'b1, steps);
    for (int i = 0; i < 6; i++) begin
      c  = $urandom;
      iv = 1'(i & 1);
      drive(0, c, mix_ref(c, iv), iv, steps);
    end
`else
    for (int i = 0; i < 4; i++) begin
      c = $urandom;
      drive(0, c, mix_ref(c, 1'b0), 1'b1, steps);
    end
`endif
    idle(0);

    // d=3, PIPE=3: invariant columns then a back-to-back stream that wraps the index
    @(posedge clk);
    total = 0;
    drive(1, 32'hc6c6c6c6, 32'hc6c6c6c6, 1'b0, steps); total += steps;
    drive(1, 32'h01010101, 32'h01010101, 1'b0, steps); total += steps;
    for (int i = 0; i < 4; i++) begin
      c = $urandom;
      drive(1, c, mix_ref(c, 1'b0), 1'b0, steps);
      total += steps;
    end
    idle(1);
    check("b_full_rate", total, 6);
    repeat (6) @(posedge clk);

    // Backpressure, PIPE=2: five stalled cycles admit exactly two columns
    #1 out_ready[2] = 1'b0;
    strict[2] = 1'b0;
    k = 0;
    c = $urandom;
    prep(2, c, mix_ref(c, 1'b0), 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(2, acc);
      if (acc) begin
        k++;
        #1;
        c = $urandom;
        prep(2, c, mix_ref(c, 1'b0), 1'b0);
      end
    end
    @(negedge clk);
    check("c_bp_accepts", k, 2);
    check("c_bp_in_ready", in_ready[2], 1'b0);
    check("c_bp_out_valid", out_valid[2], 1'b1);
    @(posedge clk);
    #1 out_ready[2] = 1'b1;
    for (int n = 0; n < 64 && k < 5; n++) begin
      step(2, acc);
      if (acc) begin
        k++;
        #1;
        if (k < 5) begin
          c = $urandom;
          prep(2, c, mix_ref(c, 1'b0), 1'b0);
        end
      end
    end
    check("c_bp_total", k, 5);
    idle(2);
    repeat (6) @(posedge clk);
    check("c_bp_drained", qsize(2), 0);

    // Reset with two columns in flight, then the next column restarts at index 0
    strict[2] = 1'b1;
    c = $urandom;
    drive(2, c, mix_ref(c, 1'b0), 1'b0, steps);
    c = $urandom;
    drive(2, c, mix_ref(c, 1'b0), 1'b0, steps);
    #1;
    rst_u[2] = 1'b1;
    in_valid[2] = 1'b0;
    exp_q2.delete();
    cnt[2] = 2'd0;
    @(negedge clk);
    check("c_rstcyc_valid", out_valid[2], 1'b0);
    check("c_rstcyc_data", get_out(2), 96'h0);
    check("c_rstcyc_idx", out_idx[2], 2'd0);
    check("c_rstcyc_last", out_last[2], 1'b0);
    @(posedge clk);
    #1 rst_u[2] = 1'b0;
    @(negedge clk);
    check("c_after_rst_valid", out_valid[2], 1'b0);
    check("c_after_rst_ready", in_ready[2], 1'b1);
    @(posedge clk);
    c = $urandom;
    drive(2, c, mix_ref(c, 1'b0), 1'b0, steps);
    idle(2);

    repeat (10) @(posedge clk);
    for (int u = 0; u < 3; u++) check("queue_empty", qsize(u), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
